// File: rtl/seven_segment_display_decoder_if.sv
// Snooped display bus plus the decoded-value outputs of seven_segment_display_decoder.
// The master side drives the anode/cathode lines; the slave side is the decoder.
interface seven_segment_display_decoder_if;
    logic [3:0]  anode_in;
    logic [6:0]  cathode_in;
    logic [15:0] digits_bcd;
    logic        value_valid;
    logic        frame_strobe;
    logic        decode_error;
    logic        stalled;

    modport master (
        output anode_in, cathode_in,
        input  digits_bcd, value_valid, frame_strobe, decode_error, stalled
    );

    modport slave (
        input  anode_in, cathode_in,
        output digits_bcd, value_valid, frame_strobe, decode_error, stalled
    );
endinterface

// File: rtl/seven_segment_display_decoder.sv
// Decodes a snooped multiplexed 4-digit seven-segment bus to BCD; publishes one cycle after the confirming digit-4 capture; no backpressure.
// Hex digits A-F are legal only when SEVEN_SEGMENT_DECODER_HEX_EN is defined.
module seven_segment_display_decoder #(
    parameter int SETTLE_CYCLES     = 16,
    parameter int FRAMES_TO_CONFIRM = 2,
    parameter int STALL_CYCLES      = 1000000
) (
    input  logic                           clock_100Mhz,
    input  logic                           reset_n,
    seven_segment_display_decoder_if.slave disp
);
    localparam logic [7:0]  SETTLE_L  = 8'(SETTLE_CYCLES);
    localparam logic [2:0]  CONFIRM_L = 3'(FRAMES_TO_CONFIRM);
    localparam logic [19:0] STALL_L   = 20'(STALL_CYCLES);

    typedef enum logic [2:0] {IDLE, D1, D2, D3, D4} state_t;

    // Returns {legal, value} for an active-low a..g pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = 5'h10;
            7'b1001111: r = 5'h11;
            7'b0010010: r = 5'h12;
            7'b0000110: r = 5'h13;
            7'b1001100: r = 5'h14;
            7'b0100100: r = 5'h15;
            7'b0100000: r = 5'h16;
            7'b0001111: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0000100: r = 5'h19;
`ifdef SEVEN_SEGMENT_DECODER_HEX_EN
            7'b0001000: r = 5'h1A;
            7'b1100000: r = 5'h1B;
            7'b0110001: r = 5'h1C;
            7'b1000010: r = 5'h1D;
            7'b0110000: r = 5'h1E;
            7'b0111000: r = 5'h1F;
`endif
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    logic [3:0]  an_s1_q, an_s2_q;
    logic [6:0]  cat_s1_q, cat_s2_q;
    logic [10:0] bus_prev_q;
    logic [7:0]  settle_q, settle_d;
    logic [19:0] stall_q, stall_d;
    state_t      state_q;
    logic [15:0] frame_q, cand_q, digits_q;
    logic [2:0]  match_q;
    logic        valid_q, strobe_q, error_q, stalled_q;

    logic [10:0] bus_now;
    logic [4:0]  seg_dec;
    logic [3:0]  cap_val;
    logic [1:0]  cap_idx, cur_idx;
    state_t      cap_state;
    logic        blank, an_ok, cat_ok, capture, cap_err, cap_dig, accept;
    logic        stall_hit, frame_eq, publish;
    logic [15:0] frame_wr;
    logic [2:0]  match_next;

    assign bus_now = {an_s2_q, cat_s2_q};
    assign seg_dec = seg_decode(cat_s2_q);
    assign cat_ok  = seg_dec[4];
    assign cap_val = seg_dec[3:0];
    assign blank   = (an_s2_q == 4'b1111);

    always_comb begin
        an_ok     = 1'b1;
        cap_idx   = 2'd0;
        cap_state = D1;
        case (an_s2_q)
            4'b0111: begin cap_idx = 2'd0; cap_state = D1; end
            4'b1011: begin cap_idx = 2'd1; cap_state = D2; end
            4'b1101: begin cap_idx = 2'd2; cap_state = D3; end
            4'b1110: begin cap_idx = 2'd3; cap_state = D4; end
            default: an_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (state_q)
            D2:      cur_idx = 2'd1;
            D3:      cur_idx = 2'd2;
            default: cur_idx = 2'd0;
        endcase
    end

    // Digit 1 always (re)starts a frame; otherwise only the current or next slot is accepted.
    assign accept = (cap_idx == 2'd0) ||
                    ((state_q != IDLE) && ((cap_idx == cur_idx) || (cap_idx == cur_idx + 2'd1)));

    always_comb begin
        settle_d = settle_q;
        if (bus_now != bus_prev_q)
            settle_d = '0;
        else if (settle_q != SETTLE_L)
            settle_d = settle_q + 8'd1;
    end

    assign capture = (settle_q != SETTLE_L) && (settle_d == SETTLE_L);
    assign cap_err = capture && !blank && !(an_ok && cat_ok);
    assign cap_dig = capture && !blank && an_ok && cat_ok;

    always_comb begin
        stall_d = stall_q;
        if (capture && !blank)
            stall_d = '0;
        else if (stall_q != STALL_L)
            stall_d = stall_q + 20'd1;
    end

    assign stall_hit = (stall_q != STALL_L) && (stall_d == STALL_L);

    always_comb begin
        frame_wr = frame_q;
        case (cap_idx)
            2'd0:    frame_wr[15:12] = cap_val;
            2'd1:    frame_wr[11:8]  = cap_val;
            2'd2:    frame_wr[7:4]   = cap_val;
            default: frame_wr[3:0]   = cap_val;
        endcase
    end

    assign frame_eq   = (frame_q == cand_q);
    assign match_next = !frame_eq ? 3'd1 : (match_q == CONFIRM_L) ? match_q : match_q + 3'd1;
    assign publish    = (match_next == CONFIRM_L) && (!valid_q || (frame_q != digits_q));

    // D4 is a one-cycle completion state: confirmation and publish happen there.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            an_s1_q    <= 4'hF;
            an_s2_q    <= 4'hF;
            cat_s1_q   <= 7'h7F;
            cat_s2_q   <= 7'h7F;
            bus_prev_q <= '1;
            settle_q   <= '0;
            stall_q    <= '0;
            state_q    <= IDLE;
            frame_q    <= '0;
            cand_q     <= '0;
            digits_q   <= '0;
            match_q    <= '0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            error_q    <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            an_s1_q    <= disp.anode_in;
            an_s2_q    <= an_s1_q;
            cat_s1_q   <= disp.cathode_in;
            cat_s2_q   <= cat_s1_q;
            bus_prev_q <= bus_now;
            settle_q   <= settle_d;
            stall_q    <= stall_d;
            strobe_q   <= 1'b0;
            error_q    <= cap_err;
            if (stall_hit) begin
                stalled_q <= 1'b1;
                valid_q   <= 1'b0;
                match_q   <= '0;
                state_q   <= IDLE;
            end else if (cap_err) begin
                match_q <= '0;
                state_q <= IDLE;
            end else if (state_q == D4) begin
                cand_q  <= frame_q;
                match_q <= match_next;
                state_q <= IDLE;
                if (publish) begin
                    digits_q  <= frame_q;
                    valid_q   <= 1'b1;
                    strobe_q  <= 1'b1;
                    stalled_q <= 1'b0;
                end
            end else if (cap_dig) begin
                if (accept) begin
                    frame_q <= frame_wr;
                    state_q <= cap_state;
                end else begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign disp.digits_bcd   = digits_q;
    assign disp.value_valid  = valid_q;
    assign disp.frame_strobe = strobe_q;
    assign disp.decode_error = error_q;
    assign disp.stalled      = stalled_q;
endmodule

// File: tb/tb_seven_segment_display_decoder.sv
// Bench for seven_segment_display_decoder: a rule-level model predicts publishes and decode errors
// into queues; a negedge monitor pops and compares them whenever the DUT pulses an output.
module tb_seven_segment_display_decoder;
    localparam int SETTLE  = 16;
    localparam int CONFIRM = 2;
    localparam int STALL   = 1000;
    localparam int SLOT    = 64;
`ifdef SEVEN_SEGMENT_DECODER_HEX_EN
    localparam int N_LEGAL = 16;
`else
    localparam int N_LEGAL = 10;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_segment_display_decoder_if dif ();

    seven_segment_display_decoder #(
        .SETTLE_CYCLES    (SETTLE),
        .FRAMES_TO_CONFIRM(CONFIRM),
        .STALL_CYCLES     (STALL)
    ) dut (
        .clock_100Mhz(clk),
        .reset_n     (rst_n),
        .disp        (dif)
    );

    // Active-low a..g patterns for 0-9 then A-F.
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_pub [$];
    int          exp_err [$];
    logic [10:0] last_bus = 11'h7FF;

    int          m_pos;
    int          m_cnt;
    int          m_frame [4];
    logic [15:0] m_cand;
    logic [15:0] m_pub;
    bit          m_valid;
    bit          m_stalled;

    logic [15:0] mon_exp;
    int          mon_d;

    function automatic int seg_value(input logic [6:0] seg);
        for (int i = 0; i < N_LEGAL; i++)
            if (seg_tab[i] == seg) return i;
        return -1;
    endfunction

    function automatic int anode_digit(input logic [3:0] an);
        case (an)
            4'b0111: return 1;
            4'b1011: return 2;
            4'b1101: return 3;
            4'b1110: return 4;
            4'b1111: return 0;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] anode_of(input int d);
        return 4'b1111 ^ (4'b1000 >> (d - 1));
    endfunction

    function automatic logic [6:0] bad_seg();
        logic [6:0] c;
        do c = 7'($urandom_range(0, 127)); while (seg_value(c) >= 0);
        return c;
    endfunction

    function automatic logic [3:0] bad_anode();
        logic [3:0] a;
        do a = 4'($urandom_range(0, 15)); while (anode_digit(a) != -1);
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_cnt = 0; m_cand = '0; m_pub = '0; m_valid = 0; m_stalled = 0;
        for (int i = 0; i < 4; i++) m_frame[i] = 0;
    endtask

    task automatic model_stall();
        m_stalled = 1; m_valid = 0; m_cnt = 0; m_pos = 0;
    endtask

    // One capture of a stable slot, applied with the frame-assembly and confirmation rules.
    task automatic model_capture(input logic [3:0] an, input logic [6:0] cat);
        int d;
        int v;
        logic [15:0] val;
        d = anode_digit(an);
        v = seg_value(cat);
        if (d == 0) return;
        if (d < 0 || v < 0) begin
            exp_err.push_back(d);
            m_cnt = 0;
            m_pos = 0;
            return;
        end
        if (d == 1 || (m_pos > 0 && (d == m_pos || d == m_pos + 1))) begin
            m_frame[d-1] = v;
            m_pos = d;
        end else begin
            m_pos = 0;
            return;
        end
        if (m_pos == 4) begin
            m_pos = 0;
            val = {4'(m_frame[0]), 4'(m_frame[1]), 4'(m_frame[2]), 4'(m_frame[3])};
            if (val == m_cand) m_cnt = (m_cnt < CONFIRM) ? m_cnt + 1 : CONFIRM;
            else begin
                m_cand = val;
                m_cnt = 1;
            end
            if (m_cnt >= CONFIRM && (!m_valid || m_cand != m_pub)) begin
                m_pub = m_cand;
                m_valid = 1;
                m_stalled = 0;
                exp_pub.push_back(m_pub);
            end
        end
    endtask

    // A repeated bus value would not re-capture, so a blank gap separates identical slots.
    task automatic slot(input logic [3:0] an, input logic [6:0] cat, input int cyc);
        if ({an, cat} == last_bus) begin
            dif.anode_in = 4'hF;
            dif.cathode_in = 7'h7F;
            repeat (SLOT) @(negedge clk);
        end
        dif.anode_in = an;
        dif.cathode_in = cat;
        last_bus = {an, cat};
        model_capture(an, cat);
        repeat (cyc) @(negedge clk);
    endtask

    task automatic frame(input logic [15:0] val);
        slot(anode_of(1), seg_tab[val[15:12]], SLOT);
        slot(anode_of(2), seg_tab[val[11:8]], SLOT);
        slot(anode_of(3), seg_tab[val[7:4]], SLOT);
        slot(anode_of(4), seg_tab[val[3:0]], SLOT);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digits"}, 32'(dif.digits_bcd), 32'h0);
        check({tag, "_valid"}, 32'(dif.value_valid), 32'h0);
        check({tag, "_strobe"}, 32'(dif.frame_strobe), 32'h0);
        check({tag, "_error"}, 32'(dif.decode_error), 32'h0);
        check({tag, "_stalled"}, 32'(dif.stalled), 32'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dif.frame_strobe) begin
                n_cmp++;
                if (exp_pub.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_strobe: got digits_bcd=%h, expected no strobe", dif.digits_bcd);
                end else begin
                    mon_exp = exp_pub.pop_front();
                    if (dif.digits_bcd !== mon_exp || dif.value_valid !== 1'b1 || dif.stalled !== 1'b0) begin
                        n_err++;
                        $display("FAIL publish: got digits=%h valid=%b stalled=%b, expected digits=%h valid=1 stalled=0",
                                 dif.digits_bcd, dif.value_valid, dif.stalled, mon_exp);
                    end
                end
            end
            if (dif.decode_error) begin
                n_cmp++;
                if (exp_err.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_decode_error: got pulse with anode=%b cathode=%b, expected none",
                             dif.anode_in, dif.cathode_in);
                end else begin
                    mon_d = exp_err.pop_front();
                end
            end
        end
    end

    initial begin
        int vals [4];
        int reps;
        int pick;
        dif.anode_in = 4'hF;
        dif.cathode_in = 7'h7F;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        frame(16'h1234);
        frame(16'h1234);
        frame(16'h1234);

        slot(anode_of(1), seg_tab[1], SLOT);
        slot(anode_of(2), seg_tab[2], SLOT);
        slot(anode_of(3), seg_tab[3], SLOT);
        slot(anode_of(4), seg_tab[4], SLOT / 2);
        slot(anode_of(4), seg_tab[5], SLOT / 2);
        frame(16'h1235);
        frame(16'h1235);

        slot(anode_of(1), seg_tab[1], SLOT);
        slot(anode_of(2), seg_tab[2], SLOT);
        slot(anode_of(3), 7'h7F, SLOT);
        slot(anode_of(4), seg_tab[4], SLOT);
        frame(16'h1234);
        frame(16'h1234);

        slot(anode_of(1), seg_tab[5], SLOT);
        slot(anode_of(3), seg_tab[7], SLOT);
        frame(16'h5678);
        frame(16'h5678);

        slot(4'hF, 7'h7F, STALL + 200);
        model_stall();
        check("stall_flag", 32'(dif.stalled), 32'(m_stalled));
        check("stall_valid", 32'(dif.value_valid), 32'(m_valid));
        check("stall_digits_held", 32'(dif.digits_bcd), 32'(m_pub));
        frame(16'h1234);
        check("stall_after_1_frame", 32'(dif.stalled), 32'(m_stalled));
        check("valid_after_1_frame", 32'(dif.value_valid), 32'(m_valid));
        frame(16'h1234);

        slot(anode_of(1), seg_tab[9], SLOT);
        slot(anode_of(2), seg_tab[8], SLOT);
        slot(anode_of(3), seg_tab[7], 40);
        check("pending_publish_before_reset", 32'(exp_pub.size()), 32'h0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        frame(16'h1234);
        frame(16'h1234);

        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < 4; k++)
                vals[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            reps = int'($urandom_range(1, 3));
            for (int p = 0; p < reps; p++) begin
                for (int k = 0; k < 4; k++) begin
                    pick = int'($urandom_range(0, 39));
                    if (pick == 0)      slot(anode_of(k + 1), bad_seg(), SLOT);
                    else if (pick == 1) slot(bad_anode(), seg_tab[vals[k]], SLOT);
                    else if (pick != 2) slot(anode_of(k + 1), seg_tab[vals[k]], SLOT);
                end
            end
        end

        repeat (100) @(negedge clk);
        check("pending_publishes", 32'(exp_pub.size()), 32'h0);
        check("pending_decode_errors", 32'(exp_err.size()), 32'h0);
        check("final_valid", 32'(dif.value_valid), 32'(m_valid));
        check("final_digits", 32'(dif.digits_bcd), 32'(m_pub));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seven_segment_display_decoder.md
Name: seven_segment_display_decoder

Overview:
- Receive-side counterpart of the team's multiplexed 4-digit seven-segment display driver.
- Snoops the active-low anode-select and cathode buses as driven to a Basys 3 display (or looped back from another board).
- Decodes each digit's cathode pattern back to BCD, reassembles the 4-digit value and publishes it once stable across consecutive refresh frames.
- Used as a board-level monitor and for self-checking display-driver tests.

Parameters:
- SETTLE_CYCLES, 16: cycles the synchronized bus must be unchanged before a digit is sampled (range 2..255).
- FRAMES_TO_CONFIRM, 2: consecutive identical complete frames required before publishing (range 1..7).
- STALL_CYCLES, 1000000: cycles without any digit capture before the value is declared stale (fits a 20-bit counter).

Ports:
- clock_100Mhz  input  1  100 MHz system clock
- reset_n  input  1  asynchronous, active-low reset
- anode_in  input  4  anode selects, active-low; 0111=digit1 (MS) ... 1110=digit4 (LS); asynchronous to clock
- cathode_in  input  7  segments, active-low; bit6=a, bit5=b ... bit0=g; asynchronous
- digits_bcd  output  16  published value; digit1 in [15:12] ... digit4 in [3:0]
- value_valid  output  1  high while digits_bcd holds a confirmed, non-stale value
- frame_strobe  output  1  one-cycle pulse when digits_bcd is updated
- decode_error  output  1  one-cycle pulse on an illegal cathode or anode code
- stalled  output  1  high once STALL_CYCLES pass without a capture

Behaviour:
- Reset: the interface is fixed as one clock (clock_100Mhz) and an asynchronous, active-low reset_n. While reset_n=0, all outputs are 0, all counters are 0 and the FSM is in IDLE. Reset is asserted asynchronously and released synchronously to the clock.
- Input synchronization: anode_in and cathode_in pass through a 2-flop synchronizer. All logic below sees only the synchronized copies.
- Settle counter: clears whenever the synchronized {anode,cathode} changes and saturates at SETTLE_CYCLES. A capture fires on the single cycle it reaches SETTLE_CYCLES, so there is exactly one capture per stable interval.
- Anode classification at capture:
  - One-hot-low codes (0111, 1011, 1101, 1110) are legal.
  - 1111 (blank) is ignored: no capture and no error.
  - Any other code pulses decode_error and aborts the frame.
- Cathode decode (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other pattern pulses decode_error and aborts the frame.
- FSM states: IDLE, D1, D2, D3, D4.
  - IDLE: a capture of digit1 stores the digit and moves to D1. Captures of any other digit are ignored.
  - Dn: a capture of digit n+1 stores the digit and advances.
  - A capture of the same digit n overwrites that digit and stays in Dn (the value changed mid-slot).
  - A capture of digit1 restarts the frame at D1.
  - Any other digit pulses no error; the FSM returns to IDLE (resync).
  - Capture of digit4 in D3 completes the frame; the FSM returns to IDLE.
- Confirmation:
  - A completed frame equal to the held candidate increments match_cnt (saturating). Otherwise it becomes the new candidate with match_cnt=1.
  - An aborted frame clears match_cnt.
  - When match_cnt reaches FRAMES_TO_CONFIRM and (value_valid=0 or candidate != digits_bcd), the block loads digits_bcd, sets value_valid=1, pulses frame_strobe and clears stalled.
  - Latency: publish occurs on the cycle after the digit-4 capture.
  - An unchanged confirmed value produces no further strobes.
- Stall counter:
  - Clears on every capture.
  - On reaching STALL_CYCLES it sets stalled=1, clears value_valid, clears match_cnt and forces the FSM to IDLE.
  - digits_bcd keeps its last value while stalled.
- Simultaneous events: a stall cannot coincide with a capture, because a capture clears the counter first. If decode_error and a frame completion fall in the same cycle, the error wins and nothing is published.

Optional Feature:
- Macro: SEVEN_SEGMENT_DECODER_HEX_EN.
- Defined: additionally accepts A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000, decoded to 4'hA..4'hF.
- Undefined: these patterns are illegal; they pulse decode_error and abort the frame.

Test Plan:
- Drive "1234" with 64-cycle slots, order digit1..digit4, SETTLE_CYCLES=16, FRAMES_TO_CONFIRM=2 -> after the 2nd frame: digits_bcd=16'h1234, value_valid=1, a single frame_strobe; no strobe on the 3rd frame.
- Once 1234 is published, change to 1235 mid-slot of digit4 -> overwrite; after 2 frames of 1235: digits_bcd=16'h1235 with one strobe.
- Cathode 1111111 in the digit3 slot -> decode_error pulse; match_cnt cleared; no publish until 2 further clean frames.
- Anode sequence 0111, 1101 (digit2 skipped) -> FSM returns to IDLE with no error; next clean frames confirm normally.
- Hold anode_in=1111 for STALL_CYCLES -> stalled=1, value_valid=0, digits_bcd unchanged; resume 1234 -> stalled=0 after 2 frames.
- Assert reset_n=0 mid-frame while in D3 -> all outputs 0 immediately; after release, no publish until 2 complete frames.
